// File: rtl/mapper_seq_ctrl_pkg.sv
// Shared definitions for the I/Q mapper sequencer: FSM encoding, frame geometry
// constants and a small sample-counter helper.
package mapper_seq_ctrl_pkg;

    localparam int SAMPLES_PER_BIT = 4;
    localparam int BITS_PER_WORD   = 16;
    localparam int CNT_W           = 3;
    localparam int BIT_IDX_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic is_last_sample(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_W'(SAMPLES_PER_BIT - 1));
    endfunction

endpackage

// File: rtl/mapper_seq_ctrl_if.sv
// Frame RAM read port plus the serial feed shared by the I and Q mappers.
interface mapper_seq_ctrl_if #(
    parameter int ADDR_W = 6
);
    import mapper_seq_ctrl_pkg::*;

    logic                     ram_rd_en;
    logic [ADDR_W-1:0]        ram_rd_addr;
    logic [BITS_PER_WORD-1:0] ram_dout_i;
    logic [BITS_PER_WORD-1:0] ram_dout_q;
    logic [BITS_PER_WORD-1:0] FRAME_DATA_I;
    logic [BITS_PER_WORD-1:0] FRAME_DATA_Q;
    logic                     RAM_READY;
    logic [CNT_W-1:0]         CNT;

    modport master (
        output ram_rd_en, ram_rd_addr, FRAME_DATA_I, FRAME_DATA_Q, RAM_READY, CNT,
        input  ram_dout_i, ram_dout_q
    );

    modport slave (
        input  ram_rd_en, ram_rd_addr, FRAME_DATA_I, FRAME_DATA_Q, RAM_READY, CNT,
        output ram_dout_i, ram_dout_q
    );

endinterface

// File: rtl/mapper_word_shifter.sv
// 16-bit LSB-first shift register with a one-word lookahead buffer so that
// consecutive frame words stream out without a gap.
module mapper_word_shifter
    import mapper_seq_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_i,
    input  logic                     next_i,
    input  logic                     shift_i,
    input  logic                     buf_load_i,
    input  logic [BITS_PER_WORD-1:0] din_i,
    output logic [BITS_PER_WORD-1:0] data_o
);

    logic [BITS_PER_WORD-1:0] data_q, data_d;
    logic [BITS_PER_WORD-1:0] buf_q,  buf_d;

    // Direct RAM load wins over buffer swap, which wins over a plain shift.
    always_comb begin
        data_d = data_q;
        buf_d  = buf_q;
        if (load_i) begin
            data_d = din_i;
        end else if (next_i) begin
            data_d = buf_q;
        end else if (shift_i) begin
            data_d = {1'b0, data_q[BITS_PER_WORD-1:1]};
        end else begin
            data_d = data_q;
        end
        if (buf_load_i) begin
            buf_d = din_i;
        end else begin
            buf_d = buf_q;
        end
    end

    // Shift and buffer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            buf_q  <= '0;
        end else begin
            data_q <= data_d;
            buf_q  <= buf_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/mapper_seq_ctrl.sv
// Frame sequencer: fetches I/Q words from the frame RAM and serialises them
// LSB-first to the mappers at SAMPLES_PER_BIT cycles per bit.
module mapper_seq_ctrl
    import mapper_seq_ctrl_pkg::*;
#(
    parameter int FRAME_WORDS = 64,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    mapper_seq_ctrl_if.master bus
);

    localparam logic [ADDR_W-1:0]    LAST_WORD = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(BITS_PER_WORD - 1);
    localparam logic [BIT_IDX_W-1:0] PF_BIT    = BIT_IDX_W'(BITS_PER_WORD - 2);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [ADDR_W-1:0]      word_idx_q, word_idx_d;
    logic                   rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   load_s, next_s, shift_s, buf_load_s;
    logic                   more_words_s;
    logic [BITS_PER_WORD-1:0] data_i_s, data_q_s;

    assign more_words_s = (word_idx_q != LAST_WORD);

    // Next-state and registered-output decode; abort overrides everything last.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        word_idx_d = word_idx_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        ready_d    = 1'b0;
        done_d     = 1'b0;
        load_s     = 1'b0;
        next_s     = 1'b0;
        shift_s    = 1'b0;
        buf_load_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d   = ST_FETCH;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d    = ST_RUN;
                load_s     = 1'b1;
                cnt_d      = '0;
                bit_idx_d  = '0;
                word_idx_d = '0;
                ready_d    = 1'b1;
            end
            ST_RUN: begin
                ready_d = 1'b1;
                if (is_last_sample(cnt_q)) begin
                    cnt_d = '0;
                    if (bit_idx_q != LAST_BIT) begin
                        shift_s   = 1'b1;
                        bit_idx_d = bit_idx_q + 4'd1;
                        // Read ahead so the next word is in the buffer before bit 15 ends.
                        if ((bit_idx_q == PF_BIT) && more_words_s) begin
                            rd_en_d   = 1'b1;
                            rd_addr_d = word_idx_q + ADDR_W'(1);
                        end else begin
                            rd_en_d = 1'b0;
                        end
                    end else if (more_words_s) begin
                        next_s     = 1'b1;
                        bit_idx_d  = '0;
                        word_idx_d = word_idx_q + ADDR_W'(1);
                    end else begin
                        state_d = ST_DONE;
                        ready_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d      = cnt_q + 3'd1;
                    buf_load_s = (bit_idx_q == LAST_BIT) && (cnt_q == 3'd1) && more_words_s;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            rd_en_d    = 1'b0;
            ready_d    = 1'b0;
            done_d     = 1'b0;
            load_s     = 1'b0;
            next_s     = 1'b0;
            shift_s    = 1'b0;
            buf_load_s = 1'b0;
        end else begin
            state_d = state_d;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            word_idx_q <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            word_idx_q <= word_idx_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    mapper_word_shifter u_shift_i (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load_s),
        .next_i     (next_s),
        .shift_i    (shift_s),
        .buf_load_i (buf_load_s),
        .din_i      (bus.ram_dout_i),
        .data_o     (data_i_s)
    );

    mapper_word_shifter u_shift_q (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load_s),
        .next_i     (next_s),
        .shift_i    (shift_s),
        .buf_load_i (buf_load_s),
        .din_i      (bus.ram_dout_q),
        .data_o     (data_q_s)
    );

    assign bus.ram_rd_en    = rd_en_q;
    assign bus.ram_rd_addr  = rd_addr_q;
    assign bus.RAM_READY    = ready_q;
    assign bus.CNT          = cnt_q;
    assign bus.FRAME_DATA_I = data_i_s;
    assign bus.FRAME_DATA_Q = data_q_s;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_mapper_seq_ctrl.sv
// Directed bench: three sequencer instances (1, 2 and 64 words per frame)
// each fed by a one-cycle-latency frame RAM model.
module tb_mapper_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        start_s [3];
    logic        abort_s [3];
    logic        busy_w  [3];
    logic        done_w  [3];
    logic        rdy_w   [3];
    logic        rden_w  [3];
    logic [5:0]  addr_w  [3];
    logic [2:0]  cnt_w   [3];
    logic [15:0] fdi_w   [3];
    logic [15:0] fdq_w   [3];
    logic [15:0] mem_i   [3][64];
    logic [15:0] mem_q   [3][64];

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mapper_seq_ctrl_if #(.ADDR_W(6)) bus ();

        mapper_seq_ctrl #(
            .FRAME_WORDS ((g == 0) ? 1 : ((g == 1) ? 2 : 64)),
            .ADDR_W      (6)
        ) dut (
            .clk   (clk),
            .reset (reset),
            .start (start_s[g]),
            .abort (abort_s[g]),
            .busy  (busy_w[g]),
            .done  (done_w[g]),
            .bus   (bus)
        );

        // Frame RAM: data appears the cycle after the read enable.
        always @(posedge clk) begin
            if (bus.ram_rd_en) begin
                bus.ram_dout_i <= mem_i[g][bus.ram_rd_addr];
                bus.ram_dout_q <= mem_q[g][bus.ram_rd_addr];
            end
        end

        assign rdy_w[g]  = bus.RAM_READY;
        assign rden_w[g] = bus.ram_rd_en;
        assign addr_w[g] = bus.ram_rd_addr;
        assign cnt_w[g]  = bus.CNT;
        assign fdi_w[g]  = bus.FRAME_DATA_I;
        assign fdq_w[g]  = bus.FRAME_DATA_Q;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start pulse launched after edge N; sampled at N+1, RUN visible after N+3.
    task automatic kick(input int g);
        @(posedge clk); #1 start_s[g] = 1'b1;
        @(posedge clk); #1 start_s[g] = 1'b0;
        chk("fetch_busy", 32'(busy_w[g]), 32'd1);
        chk("fetch_rden", 32'(rden_w[g]), 32'd1);
        chk("fetch_addr", 32'(addr_w[g]), 32'd0);
        chk("fetch_rdy",  32'(rdy_w[g]),  32'd0);
        @(posedge clk); #1;
        chk("load_rdy",   32'(rdy_w[g]),  32'd0);
        chk("load_rden",  32'(rden_w[g]), 32'd0);
        @(posedge clk); #1;
        chk("first_rdy",  32'(rdy_w[g]),  32'd1);
    endtask

    task automatic run_frame(input int g, input int nw, input int abort_at, input int restart_at,
                             input int exp_len, input int exp_pf, input int exp_done);
        int k, w, b, pf, bad_dat, bad_cnt, bad_pf;
        logic [15:0] ei, eq;
        k = 0; pf = 0; bad_dat = 0; bad_cnt = 0; bad_pf = 0;
        kick(g);
        while (rdy_w[g] === 1'b1 && k < nw * 64 + 8) begin
            w  = k / 64;
            b  = (k / 4) % 16;
            ei = mem_i[g][w % 64] >> b;
            eq = mem_q[g][w % 64] >> b;
            if (fdi_w[g] !== ei || fdq_w[g] !== eq) bad_dat++;
            if (cnt_w[g] !== 3'(k % 4)) bad_cnt++;
            if (rden_w[g] === 1'b1) begin
                pf++;
                if (addr_w[g] !== 6'(w + 1) || b != 15 || (k % 4) != 0) bad_pf++;
            end
            abort_s[g] = (k == abort_at);
            start_s[g] = (k == restart_at);
            @(posedge clk); #1;
            k++;
        end
        abort_s[g] = 1'b0;
        start_s[g] = 1'b0;
        chk("run_len",     32'(k),          32'(exp_len));
        chk("stream_data", 32'(bad_dat),    32'd0);
        chk("cnt_seq",     32'(bad_cnt),    32'd0);
        chk("prefetch_n",  32'(pf),         32'(exp_pf));
        chk("prefetch_at", 32'(bad_pf),     32'd0);
        chk("end_done",    32'(done_w[g]),  32'(exp_done));
        chk("end_busy",    32'(busy_w[g]),  32'(exp_done));
        chk("end_cnt",     32'(cnt_w[g]),   32'd0);
        chk("end_rden",    32'(rden_w[g]),  32'd0);
        @(posedge clk); #1;
        chk("post_done",   32'(done_w[g]),  32'd0);
        chk("post_busy",   32'(busy_w[g]),  32'd0);
        chk("post_rdy",    32'(rdy_w[g]),   32'd0);
    endtask

    initial begin
        reset = 1'b0;
        for (int g = 0; g < 3; g++) begin
            start_s[g] = 1'b0;
            abort_s[g] = 1'b0;
            for (int w = 0; w < 64; w++) begin
                mem_i[g][w] = 16'h0000;
                mem_q[g][w] = 16'h0000;
            end
        end
        mem_i[0][0] = 16'h0001;
        mem_q[0][0] = 16'h0002;
        mem_i[1][0] = 16'hFFFF;
        mem_i[1][1] = 16'h0000;
        mem_q[1][0] = 16'hA5C3;
        mem_q[1][1] = 16'h3C5A;
        for (int w = 0; w < 64; w++) begin
            mem_i[2][w] = 16'($urandom);
            mem_q[2][w] = 16'($urandom);
        end

        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("rst_rdy",  32'(rdy_w[g]),  32'd0);
            chk("rst_cnt",  32'(cnt_w[g]),  32'd0);
            chk("rst_fdi",  32'(fdi_w[g]),  32'd0);
            chk("rst_fdq",  32'(fdq_w[g]),  32'd0);
            chk("rst_busy", 32'(busy_w[g]), 32'd0);
            chk("rst_done", 32'(done_w[g]), 32'd0);
            chk("rst_rden", 32'(rden_w[g]), 32'd0);
            chk("rst_addr", 32'(addr_w[g]), 32'd0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy_w[0]), 32'd0);

        // One word: 64 RUN cycles, no prefetch, done right after.
        run_frame(0, 1, -1, -1, 64, 0, 1);
        // Two words: one prefetch of address 1, 128 contiguous RUN cycles.
        run_frame(1, 2, -1, -1, 128, 1, 1);
        // Abort at RUN cycle 10: RUN ends after 11 sampled cycles, no done.
        run_frame(1, 2, 10, -1, 11, 0, 0);
        // Start re-pulsed at RUN cycle 20 is ignored.
        run_frame(1, 2, -1, 20, 128, 1, 1);
        // Full 64-word random frame.
        run_frame(2, 64, -1, -1, 4096, 63, 1);

        // Asynchronous reset in the middle of a RUN.
        kick(2);
        repeat (100) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_rdy",  32'(rdy_w[2]),  32'd0);
        chk("arst_cnt",  32'(cnt_w[2]),  32'd0);
        chk("arst_fdi",  32'(fdi_w[2]),  32'd0);
        chk("arst_fdq",  32'(fdq_w[2]),  32'd0);
        chk("arst_busy", 32'(busy_w[2]), 32'd0);
        chk("arst_rden", 32'(rden_w[2]), 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("norsm_busy", 32'(busy_w[2]), 32'd0);
        chk("norsm_rdy",  32'(rdy_w[2]),  32'd0);
        chk("norsm_rden", 32'(rden_w[2]), 32'd0);
        chk("norsm_cnt",  32'(cnt_w[2]),  32'd0);

        run_frame(0, 1, -1, -1, 64, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mapper_seq_ctrl.md
MAPPER_SEQ_CTRL -- requirements
Module: mapper_seq_ctrl

Interface
REQ-001 Parameter FRAME_WORDS, default 64, SHALL be the number of 16-bit I/Q word pairs per frame (legal range 1..2^ADDR_W).
REQ-002 Parameter ADDR_W, default 6, SHALL be the width of the frame RAM read address.
REQ-003 clk  input  1  SHALL be the single system clock; all logic is on posedge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset (0 = reset).
REQ-005 start  input  1  SHALL be a one-cycle frame start request, honoured only in IDLE.
REQ-006 abort  input  1  SHALL be a synchronous frame abort, level-sensitive.
REQ-007 ram_rd_en  output  1  SHALL be the frame RAM read enable.
REQ-008 ram_rd_addr  output  ADDR_W  SHALL be the frame RAM word address.
REQ-009 ram_dout_i, ram_dout_q  input  16 each  SHALL be the RAM read data, valid exactly 1 cycle after ram_rd_en.
REQ-010 FRAME_DATA_I, FRAME_DATA_Q  output  16 each  SHALL be shift registers whose bit 0 is the current bit fed to the I and Q mappers.
REQ-011 RAM_READY  output  1  SHALL be the mapper enable.
REQ-012 CNT  output  3  SHALL be the sample-within-bit counter (0..3) shared by both mappers.
REQ-013 busy  output  1  SHALL be high in every state except IDLE.
REQ-014 done  output  1  SHALL be a one-cycle pulse at frame completion.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, LOAD, RUN and DONE; all outputs SHALL be registered.
REQ-016 IDLE + start=1 -> FETCH; in FETCH ram_rd_en=1 and ram_rd_addr=0 for one cycle.
REQ-017 FETCH -> LOAD; in LOAD FRAME_DATA_I/Q SHALL capture ram_dout_i/q, and word_idx=0, bit_idx=0, CNT=0.
REQ-018 LOAD -> RUN; RAM_READY SHALL be 1 in every RUN cycle and 0 in all other states.
REQ-019 In RUN, CNT SHALL increment 0,1,2,3,0,... each cycle; on CNT=3 both FRAME_DATA registers SHALL shift right by one and bit_idx SHALL increment (4 cycles per bit, 64 cycles per word).
REQ-020 Prefetch: at bit_idx=15, CNT=0, if word_idx < FRAME_WORDS-1, ram_rd_en=1 and ram_rd_addr=word_idx+1 for one cycle; the data SHALL be held in a next-word buffer at CNT=1.
REQ-021 At bit_idx=15, CNT=3, when more words remain, FRAME_DATA_I/Q SHALL load the next-word buffer instead of shifting, bit_idx wraps to 0, word_idx increments, and RAM_READY SHALL stay high (no gap between words).
REQ-022 At bit_idx=15, CNT=3 of word FRAME_WORDS-1 -> DONE; no prefetch SHALL be issued for the last word.
REQ-023 DONE SHALL last one cycle with done=1, then -> IDLE.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE on the next edge: RAM_READY=0, ram_rd_en=0, CNT=0, no done pulse; abort has priority over start and over all RUN transitions.
REQ-026 Counter widths: bit_idx 4 bits and word_idx ADDR_W bits, with no wrap-around beyond FRAME_WORDS-1.
REQ-027 Latency SHALL be: start at edge N -> first RAM_READY=1 at edge N+3; frame length in RUN = FRAME_WORDS*64 cycles exactly.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE and zero every output, the next-word buffer, and all counters.
REQ-029 Reset release mid-frame SHALL NOT resume; a new start is required.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, SAMPLES_PER_BIT=4, and BITS_PER_WORD=16.
REQ-031 A single sub-module, mapper_word_shifter (16-bit load/shift register with next-word buffer), SHALL be instantiated twice (I and Q).
REQ-032 The block SHALL drive both mapping instances (I and Q) through FRAME_DATA_I/Q, RAM_READY and CNT.

Verification
REQ-033 FRAME_WORDS=1, RAM word0 I=16'h0001, Q=16'h0002, start pulse -> RAM_READY high for exactly 64 cycles; FRAME_DATA_I[0]=1 for cycles 0-3, then 0; FRAME_DATA_Q[0]=0, then 1 for cycles 4-7; done pulse 1 cycle after the last RUN cycle.
REQ-034 FRAME_WORDS=2, I words 16'hFFFF, 16'h0000 -> exactly one prefetch at addr 1; RAM_READY continuous for 128 cycles; FRAME_DATA_I[0] goes 1->0 at RUN cycle 64.
REQ-035 abort asserted at RUN cycle 10 -> IDLE next edge; RAM_READY=0, CNT=0, busy=0, no done pulse.
REQ-036 start re-pulsed at RUN cycle 20 -> ignored; total RUN length unchanged.
REQ-037 reset=0 asynchronously mid-RUN -> all outputs 0 immediately; after release, the block stays IDLE until start.
REQ-038 FRAME_WORDS=64, random data -> bit-exact serialized stream LSB-first per word; CNT sequence 0..3 never skipped.
